// File: rtl/ibex_mem_port_arbiter.sv
// Shares one req/gnt/rvalid memory port between the Ibex fetch and data interfaces.
// Define IBEX_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise data has fixed priority.
module ibex_mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic [2:0]  outstanding_o,
  output logic        protocol_err_o
);

  localparam int PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int DEPTH = 2 ** PW;
  localparam logic [2:0]    MaxCnt  = 3'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LastPtr = PW'(MAX_OUTSTANDING - 1);

  typedef enum logic {ID_INSTR = 1'b0, ID_DATA = 1'b1} req_id_e;

  logic          r_lock;
  req_id_e       r_lock_id;
  req_id_e       r_last;
  req_id_e       r_fifo [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [2:0]    r_count;
  logic          r_protocol_err;

  req_id_e w_win_id;
  req_id_e w_head_id;
  logic    w_full;
  logic    w_xfer;
  logic    w_pop;
  logic    w_spurious;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_win_id = ID_INSTR;
    if (r_lock) begin
      w_win_id = r_lock_id;
    end else if (instr_req_i && data_req_i) begin
`ifdef IBEX_ARB_ROUND_ROBIN_EN
      w_win_id = (r_last == ID_DATA) ? ID_INSTR : ID_DATA;
`else
      // Last-granted is tracked in both builds; OR-ing with 1 pins data as the winner.
      w_win_id = req_id_e'(r_last | 1'b1);
`endif
    end else if (data_req_i) begin
      w_win_id = ID_DATA;
    end
  end

  assign w_full     = (r_count == MaxCnt);
  assign mem_req_o  = !w_full && (r_lock || instr_req_i || data_req_i);
  assign w_xfer     = mem_req_o && mem_gnt_i;
  assign w_head_id  = r_fifo[r_rptr];
  assign w_pop      = mem_rvalid_i && (r_count != 3'd0);
  assign w_spurious = mem_rvalid_i && (r_count == 3'd0);

  assign instr_gnt_o = w_xfer && (w_win_id == ID_INSTR);
  assign data_gnt_o  = w_xfer && (w_win_id == ID_DATA);

  assign mem_we_o    = (w_win_id == ID_DATA) && data_we_i;
  assign mem_be_o    = (w_win_id == ID_DATA) ? data_be_i    : 4'hF;
  assign mem_addr_o  = (w_win_id == ID_DATA) ? data_addr_i  : instr_addr_i;
  assign mem_wdata_o = (w_win_id == ID_DATA) ? data_wdata_i : 32'h0;

  assign instr_rvalid_o = w_pop && (w_head_id == ID_INSTR);
  assign data_rvalid_o  = w_pop && (w_head_id == ID_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;

  assign outstanding_o  = r_count;
  assign protocol_err_o = r_protocol_err;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock         <= 1'b0;
      r_lock_id      <= ID_INSTR;
      r_last         <= ID_DATA;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= 3'd0;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_lock <= 1'b0;
        r_last <= w_win_id;
        r_wptr <= ptr_inc(r_wptr);
      end else if (mem_req_o) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_win_id;
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_xfer, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_spurious) begin
        r_protocol_err <= 1'b1;
      end
    end
  end

  // NOTE: ID storage has no reset; an entry is only read while the count says it is valid.
  always_ff @(posedge clk_i) begin
    if (w_xfer) begin
      r_fifo[r_wptr] <= w_win_id;
    end
  end

endmodule

// File: tb/tb_ibex_mem_port_arbiter.sv
// Directed bench for ibex_mem_port_arbiter: queue-based reference model checked every cycle plus literal spot checks.
module tb_ibex_mem_port_arbiter;

  localparam int MAX = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i, mem_we_o, mem_err_i;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [2:0]  outstanding_o;
  logic        protocol_err_o;

  ibex_mem_port_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, {31'h0, act}, {31'h0, exp});
  endtask

  // Reference model: in-flight IDs as a queue (0 = instr, 1 = data), a pending winner, and the sticky error.
  bit m_q[$];
  int m_held = -1;
  bit m_last = 1'b1;
  bit m_perr = 1'b0;

  task automatic model_step();
    bit full, any, e_req, e_xfer, win, rv_i, rv_d, h;
    full  = (m_q.size() == MAX);
    any   = (m_held >= 0) || instr_req_i || data_req_i;
    e_req = !full && any;
    if (m_held >= 0)                    win = (m_held == 1);
    else if (instr_req_i && data_req_i)
`ifdef IBEX_ARB_ROUND_ROBIN_EN
                                        win = !m_last;
`else
                                        win = 1'b1;
`endif
    else                                win = data_req_i;
    e_xfer = e_req && mem_gnt_i;

    check1("mem_req", mem_req_o, e_req);
    check1("instr_gnt", instr_gnt_o, e_xfer && !win);
    check1("data_gnt", data_gnt_o, e_xfer && win);
    if (e_req) begin
      check32("mem_addr", mem_addr_o, win ? data_addr_i : instr_addr_i);
      check1("mem_we", mem_we_o, win && data_we_i);
      check32("mem_be", {28'h0, mem_be_o}, {28'h0, win ? data_be_i : 4'hF});
      check32("mem_wdata", mem_wdata_o, win ? data_wdata_i : 32'h0);
    end
    check32("outstanding", {29'h0, outstanding_o}, 32'(m_q.size()));
    check1("protocol_err", protocol_err_o, m_perr);

    rv_i = 1'b0;
    rv_d = 1'b0;
    if (mem_rvalid_i) begin
      if (m_q.size() == 0) begin
        m_perr = 1'b1;
      end else begin
        h    = m_q.pop_front();
        rv_i = !h;
        rv_d = h;
      end
    end
    check1("instr_rvalid", instr_rvalid_o, rv_i);
    check1("data_rvalid", data_rvalid_o, rv_d);
    if (rv_i) begin
      check32("instr_rdata", instr_rdata_o, mem_rdata_i);
      check1("instr_err", instr_err_o, mem_err_i);
    end
    if (rv_d) begin
      check32("data_rdata", data_rdata_o, mem_rdata_i);
      check1("data_err", data_err_o, mem_err_i);
    end

    if (e_xfer) begin
      m_q.push_back(win);
      m_held = -1;
      m_last = win;
    end else if (e_req) begin
      m_held = win ? 1 : 0;
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      m_q.delete();
      m_held = -1;
      m_last = 1'b1;
      m_perr = 1'b0;
      check32("rst_outstanding", {29'h0, outstanding_o}, 32'h0);
      check1("rst_protocol_err", protocol_err_o, 1'b0);
      check1("rst_instr_rvalid", instr_rvalid_o, 1'b0);
      check1("rst_data_rvalid", data_rvalid_o, 1'b0);
    end else begin
      model_step();
    end
  end

  task automatic idle();
    instr_req_i = 0; instr_addr_i = 32'h0;
    data_req_i = 0; data_we_i = 0; data_be_i = 4'h0; data_addr_i = 32'h0; data_wdata_i = 32'h0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 32'h0; mem_err_i = 0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
  endtask

  int n_dgnt;

  initial begin
    idle();
    rst_ni = 1'b0;
    at_neg();
    tick(); tick();
    rst_ni = 1'b1;

    // Single fetch
    idle(); instr_req_i = 1; instr_addr_i = 32'h80; mem_gnt_i = 1;
    at_neg();
    check1("t1_instr_gnt", instr_gnt_o, 1'b1);
    check32("t1_be", {28'h0, mem_be_o}, 32'hF);
    check1("t1_we", mem_we_o, 1'b0);
    check32("t1_addr", mem_addr_o, 32'h80);
    tick();
    idle(); mem_rvalid_i = 1; mem_rdata_i = 32'h13;
    at_neg();
    check32("t1_outstanding_1", {29'h0, outstanding_o}, 32'd1);
    check1("t1_rvalid", instr_rvalid_o, 1'b1);
    check32("t1_rdata", instr_rdata_o, 32'h13);
    tick();
    idle();
    at_neg();
    check32("t1_outstanding_0", {29'h0, outstanding_o}, 32'd0);
    tick();

    // Grant stall and lock: instr held at 0x100 while data arrives
    idle(); instr_req_i = 1; instr_addr_i = 32'h100;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        data_req_i = 1; data_addr_i = 32'h200; data_be_i = 4'hF;
      end
      at_neg();
      check32("t2_stall_addr", mem_addr_o, 32'h100);
      check1("t2_stall_data_gnt", data_gnt_o, 1'b0);
      tick();
    end
    mem_gnt_i = 1;
    at_neg();
    check1("t2_instr_gnt", instr_gnt_o, 1'b1);
    check1("t2_data_gnt_lo", data_gnt_o, 1'b0);
    check32("t2_addr_lock", mem_addr_o, 32'h100);
    tick();
    instr_req_i = 0;
    at_neg();
    check1("t2_data_gnt", data_gnt_o, 1'b1);
    check32("t2_data_addr", mem_addr_o, 32'h200);
    tick();
    idle(); mem_rvalid_i = 1;
    at_neg();
    check32("t2_outstanding_2", {29'h0, outstanding_o}, 32'd2);
    check1("t2_first_rvalid_instr", instr_rvalid_o, 1'b1);
    tick();
    at_neg();
    check1("t2_second_rvalid_data", data_rvalid_o, 1'b1);
    tick();

    // Arbitration policy: both request every cycle
    n_dgnt = 0;
    for (int i = 0; i < 4; i++) begin
      idle(); instr_req_i = 1; instr_addr_i = 32'h400; data_req_i = 1; data_addr_i = 32'h500;
      data_be_i = 4'hF; mem_gnt_i = 1; mem_rvalid_i = (i > 0);
      at_neg();
`ifdef IBEX_ARB_ROUND_ROBIN_EN
      check1("t3_rr_instr_gnt", instr_gnt_o, (i % 2) == 0);
`else
      check1("t3_fixed_instr_gnt", instr_gnt_o, 1'b0);
`endif
      if (data_gnt_o) n_dgnt++;
      tick();
    end
    idle(); mem_rvalid_i = 1;
    at_neg();
    tick();
`ifdef IBEX_ARB_ROUND_ROBIN_EN
    check32("t3_data_grants", 32'(n_dgnt), 32'd2);
`else
    check32("t3_data_grants", 32'(n_dgnt), 32'd4);
`endif

    // Full FIFO
    idle(); data_req_i = 1; data_addr_i = 32'h600; data_be_i = 4'hF; mem_gnt_i = 1;
    at_neg(); tick();
    at_neg(); tick();
    at_neg();
    check1("t4_full_req", mem_req_o, 1'b0);
    check32("t4_full_outstanding", {29'h0, outstanding_o}, 32'd2);
    check1("t4_full_gnt", data_gnt_o, 1'b0);
    tick();
    mem_rvalid_i = 1;
    at_neg();
    check1("t4_pop_cycle_req", mem_req_o, 1'b0);
    check1("t4_pop_rvalid", data_rvalid_o, 1'b1);
    tick();
    mem_rvalid_i = 0; mem_gnt_i = 0;
    at_neg();
    check1("t4_after_pop_req", mem_req_o, 1'b1);
    check32("t4_after_pop_outstanding", {29'h0, outstanding_o}, 32'd1);
    tick();
    mem_gnt_i = 1;
    at_neg();
    check1("t4_regrant", data_gnt_o, 1'b1);
    tick();
    idle(); mem_rvalid_i = 1;
    at_neg(); tick();
    at_neg(); tick();

    // Response ordering with error
    idle(); data_req_i = 1; data_we_i = 1; data_be_i = 4'h3; data_addr_i = 32'h300;
    data_wdata_i = 32'hDEADBEEF; mem_gnt_i = 1;
    at_neg();
    check1("t5_we", mem_we_o, 1'b1);
    check32("t5_be", {28'h0, mem_be_o}, 32'h3);
    check32("t5_wdata", mem_wdata_o, 32'hDEADBEEF);
    tick();
    idle(); instr_req_i = 1; instr_addr_i = 32'h84; mem_gnt_i = 1;
    at_neg();
    check1("t5_instr_gnt", instr_gnt_o, 1'b1);
    tick();
    idle(); mem_rvalid_i = 1; mem_err_i = 1; mem_rdata_i = 32'hAAAA5555;
    at_neg();
    check1("t5_data_rvalid", data_rvalid_o, 1'b1);
    check1("t5_data_err", data_err_o, 1'b1);
    check1("t5_no_instr_rvalid", instr_rvalid_o, 1'b0);
    tick();
    mem_err_i = 0; mem_rdata_i = 32'h11;
    at_neg();
    check1("t5_instr_rvalid", instr_rvalid_o, 1'b1);
    check1("t5_instr_err", instr_err_o, 1'b0);
    check1("t5_no_data_rvalid", data_rvalid_o, 1'b0);
    tick();

    // Reset with two in flight, then a spurious response
    idle(); instr_req_i = 1; instr_addr_i = 32'h88; mem_gnt_i = 1;
    tick();
    idle(); data_req_i = 1; data_addr_i = 32'h700; data_be_i = 4'hF; mem_gnt_i = 1;
    tick();
    idle();
    at_neg();
    check32("t6_inflight", {29'h0, outstanding_o}, 32'd2);
    tick();
    rst_ni = 1'b0;
    at_neg();
    check32("t6_rst_outstanding", {29'h0, outstanding_o}, 32'd0);
    tick();
    rst_ni = 1'b1; mem_rvalid_i = 1;
    at_neg();
    check1("t6_spur_instr_rvalid", instr_rvalid_o, 1'b0);
    check1("t6_spur_data_rvalid", data_rvalid_o, 1'b0);
    tick();
    idle();
    at_neg();
    check1("t6_protocol_err", protocol_err_o, 1'b1);
    check32("t6_outstanding", {29'h0, outstanding_o}, 32'd0);
    tick();
    at_neg();
    check1("t6_protocol_err_sticky", protocol_err_o, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
